ps2_key_tracker: RTL and testbench

- Consumes the scan-code byte stream from ps2_keyboard (data/ready/nextdata_n FIFO interface).
- Decodes make, break and E0-extended sequences, and tracks up to N_KEYS simultaneously held keys in press order.
- Counts distinct presses and produces case-correct ASCII for the most recently pressed held key.
- Sits between ps2_keyboard and the seven-segment/LED display logic in top-level designs.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_key_tracker_if.sv | 10 +
 rtl/ps2_ascii_map.sv | 42 ++++
 rtl/ps2_key_tracker.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state types and held-key entry type for the
// PS/2 key tracker and its ASCII map.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {F_IDLE, F_POP, F_PROC} fetch_state_t;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_ent_t;

  function automatic logic is_shift(key_ent_t k);
    return !k.ext && (k.code == SC_LSHIFT || k.code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte FIFO handshake between ps2_keyboard (master) and the key tracker (slave):
// head byte + non-empty flag, active-low one-cycle pop strobe back.
interface ps2_key_tracker_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       nextdata_n;

  modport master (output ps2_data, output ps2_ready, input nextdata_n);
  modport slave  (input ps2_data, input ps2_ready, output nextdata_n);
endinterface

// File: rtl/ps2_ascii_map.sv
// Combinational set-2 scan code to ASCII: letters follow shift XOR caps,
// digits/space/enter fixed, extended or unmapped codes give 00.
module ps2_ascii_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = (letter != 8'h00 && (shift ^ caps)) ? letter - 8'h20 : letter;
    endcase
    if (ext) ascii = 8'h00;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Scan-code decoder + press-ordered held-key table. One byte per 3 cycles;
// results appear the cycle after F_PROC; pops the FIFO only from F_POP.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int CNT_W         = 8,
  parameter bit IGNORE_REPEAT = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ps2_key_tracker_if.slave              ps2,
  output logic                          evt_valid,
  output logic                          evt_make,
  output logic                          evt_ext,
  output logic [7:0]                    evt_code,
  output logic [7:0]                    cur_code,
  output logic                          cur_ext,
  output logic [7:0]                    ascii,
  output logic [$clog2(N_KEYS+1)-1:0]   held_cnt,
  output logic [CNT_W-1:0]              press_cnt,
  output logic                          caps,
  output logic                          overflow
);

  localparam int CW = $clog2(N_KEYS + 1);

  fetch_state_t f_state, f_next;
  dec_state_t   d_state, d_next;
  logic [7:0]   byte_q;
  logic         dec_make, dec_brk, dec_ext;
  key_ent_t     tbl [N_KEYS];
  key_ent_t     new_ent, cur_ent;
  logic         hit, full, shift_on, evt_fire, accept;
  logic [CW-1:0] hit_idx;
  logic [7:0]   map_ascii;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      f_state <= F_IDLE;
      d_state <= D_BASE;
      byte_q  <= '0;
    end else begin
      f_state <= f_next;
      d_state <= d_next;
      if (f_state == F_POP) byte_q <= ps2.ps2_data;
    end
  end

  always_comb begin
    f_next         = f_state;
    ps2.nextdata_n = 1'b1;
    case (f_state)
      F_IDLE:  if (ps2.ps2_ready) f_next = F_POP;
      F_POP:   begin ps2.nextdata_n = 1'b0; f_next = F_PROC; end
      F_PROC:  f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  always_comb begin
    d_next   = d_state;
    dec_make = 1'b0;
    dec_brk  = 1'b0;
    dec_ext  = 1'b0;
    if (f_state == F_PROC) begin
      case (d_state)
        D_BASE: begin
          if (byte_q == SC_E0)      d_next = D_EXT;
          else if (byte_q == SC_F0) d_next = D_BRK;
          else if (!(byte_q inside {SC_E1, 8'hAA, 8'hFA, 8'h00, 8'hFF})) dec_make = 1'b1;
        end
        D_EXT: begin
          if (byte_q == SC_F0) d_next = D_EXT_BRK;
          else if (byte_q != SC_E0) begin
            dec_make = 1'b1;
            dec_ext  = 1'b1;
            d_next   = D_BASE;
          end
        end
        D_BRK:     begin dec_brk = 1'b1; d_next = D_BASE; end
        D_EXT_BRK: begin dec_brk = 1'b1; dec_ext = 1'b1; d_next = D_BASE; end
        default:   d_next = D_BASE;
      endcase
    end
  end

  // Slots at or above held_cnt are kept zero, so a removal can shift the whole upper part.
  always_comb begin
    new_ent.ext  = dec_ext;
    new_ent.code = byte_q;
    hit      = 1'b0;
    hit_idx  = '0;
    shift_on = 1'b0;
    cur_ent  = '0;
    for (int j = 0; j < N_KEYS; j++) begin
      if (CW'(j) < held_cnt) begin
        if (!hit && tbl[j] == new_ent) begin
          hit     = 1'b1;
          hit_idx = CW'(j);
        end
        if (is_shift(tbl[j])) shift_on = 1'b1;
      end
      if (CW'(j + 1) == held_cnt) cur_ent = tbl[j];
    end
  end

  assign full     = (held_cnt == CW'(N_KEYS));
  assign evt_fire = dec_brk | (dec_make & (~hit | ~IGNORE_REPEAT));
  assign accept   = dec_make & ~hit & ~full;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int j = 0; j < N_KEYS; j++) tbl[j] <= '0;
      held_cnt  <= '0;
      press_cnt <= '0;
      caps      <= 1'b0;
      overflow  <= 1'b0;
      evt_valid <= 1'b0;
      evt_make  <= 1'b0;
      evt_ext   <= 1'b0;
      evt_code  <= '0;
    end else begin
      evt_valid <= evt_fire;
      if (evt_fire) begin
        evt_make <= dec_make;
        evt_ext  <= dec_ext;
        evt_code <= byte_q;
      end
      if (dec_make && hit && !IGNORE_REPEAT) press_cnt <= press_cnt + CNT_W'(1);
      if (dec_make && !hit && full) overflow <= 1'b1;
      if (accept) begin
        for (int j = 0; j < N_KEYS; j++)
          if (CW'(j) == held_cnt) tbl[j] <= new_ent;
        held_cnt  <= held_cnt + CW'(1);
        press_cnt <= press_cnt + CNT_W'(1);
        overflow  <= 1'b0;
        if (!new_ent.ext && new_ent.code == SC_CAPS) caps <= ~caps;
      end
      if (dec_brk && hit) begin
        for (int j = 0; j < N_KEYS - 1; j++)
          if (CW'(j) >= hit_idx) tbl[j] <= tbl[j+1];
        tbl[N_KEYS-1] <= '0;
        held_cnt <= held_cnt - CW'(1);
        overflow <= 1'b0;
      end
    end
  end

  ps2_ascii_map u_map (
    .code  (cur_ent.code),
    .ext   (cur_ent.ext),
    .shift (shift_on),
    .caps  (caps),
    .ascii (map_ascii)
  );

  assign cur_code = cur_ent.code;
  assign cur_ext  = cur_ent.ext;
  assign ascii    = is_shift(cur_ent) ? 8'h00 : map_ascii;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: queue-backed FIFO, list-based key model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ps2_key_tracker;

  localparam int N_KEYS = 4;
  localparam int CNT_W  = 8;
  localparam bit IGN    = 1'b1;

  logic clk = 1'b0;
  logic reset_n;
  ps2_key_tracker_if bus();
  logic evt_valid, evt_make, evt_ext, cur_ext, caps, overflow;
  logic [7:0] evt_code, cur_code, ascii;
  logic [2:0] held_cnt;
  logic [CNT_W-1:0] press_cnt;

  ps2_key_tracker #(.N_KEYS(N_KEYS), .CNT_W(CNT_W), .IGNORE_REPEAT(IGN)) dut (
    .clk(clk), .reset_n(reset_n), .ps2(bus),
    .evt_valid(evt_valid), .evt_make(evt_make), .evt_ext(evt_ext), .evt_code(evt_code),
    .cur_code(cur_code), .cur_ext(cur_ext), .ascii(ascii), .held_cnt(held_cnt),
    .press_cnt(press_cnt), .caps(caps), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo[$];
  bit         pop_flag = 0;
  bit         apply_pending = 0;
  logic [7:0] pend_byte;
  int         pop_cnt = 0;
  int         ext_evt_cnt = 0;
  logic [9:0] last_evt = '0;
  bit         prev_nd_low = 0;
  bit         nd_low;

  // Model: held keys as {ext,code} in press order, plus prefix flags.
  logic [8:0]       m_held[$];
  logic [CNT_W-1:0] m_press;
  bit               m_caps, m_ovf, m_pref_ext, m_pref_brk;
  bit               e_vld, e_make, e_ext;
  logic [7:0]       e_code;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [14] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h12, 8'h59, 8'h58, 8'h29,
                            8'h5A, 8'h45, 8'h16, 8'h75, 8'h6B};
  logic [7:0] junk [5] = '{8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [8:0] k);
    for (int i = 0; i < m_held.size(); i++) if (m_held[i] == k) return i;
    return -1;
  endfunction

  task automatic m_emit(input bit mk, input logic [8:0] k);
    e_vld = 1; e_make = mk; e_ext = k[8]; e_code = k[7:0];
  endtask

  task automatic m_make(input logic [8:0] k);
    if (m_find(k) >= 0) begin
      if (!IGN) begin m_emit(1, k); m_press++; end
    end else begin
      m_emit(1, k);
      if (m_held.size() < N_KEYS) begin
        m_held.push_back(k);
        m_press++;
        m_ovf = 0;
        if (k == 9'h058) m_caps = !m_caps;
      end else m_ovf = 1;
    end
  endtask

  task automatic m_break(input logic [8:0] k);
    int idx;
    m_emit(0, k);
    idx = m_find(k);
    if (idx >= 0) begin m_held.delete(idx); m_ovf = 0; end
  endtask

  task automatic m_step(input logic [7:0] b);
    if (m_pref_brk) begin
      m_break({m_pref_ext, b});
      m_pref_ext = 0; m_pref_brk = 0;
    end else if (b == 8'hE0) m_pref_ext = 1;
    else if (b == 8'hF0) m_pref_brk = 1;
    else if (!m_pref_ext && (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'h00 || b == 8'hFF)) begin
    end else begin
      m_make({m_pref_ext, b});
      m_pref_ext = 0;
    end
  endtask

  task automatic model_reset();
    m_held.delete();
    m_press = '0; m_caps = 0; m_ovf = 0; m_pref_ext = 0; m_pref_brk = 0;
  endtask

  function automatic logic [8:0] m_cur();
    if (m_held.size() == 0) return 9'h000;
    return m_held[m_held.size()-1];
  endfunction

  function automatic logic [7:0] m_ascii();
    logic [8:0] k;
    bit sh;
    k  = m_cur();
    sh = (m_find(9'h012) >= 0) || (m_find(9'h059) >= 0);
    if (m_held.size() == 0 || k[8]) return 8'h00;
    if (k[7:0] == 8'h12 || k[7:0] == 8'h59) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (k[7:0] == letter_sc[i]) return ((sh ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (k[7:0] == digit_sc[i]) return 8'h30 + 8'(i);
    if (k[7:0] == 8'h29) return 8'h20;
    if (k[7:0] == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  // Model advance + per-cycle compare + FIFO head update, all at negedge.
  always @(negedge clk) begin
    e_vld = 0;
    if (reset_n) begin
      model_reset();
      apply_pending = 0;
    end else if (apply_pending) begin
      m_step(pend_byte);
      apply_pending = 0;
    end
    chk("evt_valid", evt_valid, e_vld);
    if (e_vld) begin
      chk("evt_make", evt_make, e_make);
      chk("evt_ext", evt_ext, e_ext);
      chk("evt_code", evt_code, e_code);
    end
    if (reset_n) begin
      chk("rst_nextdata_n", bus.nextdata_n, 1);
      chk("rst_evt_code", {evt_make, evt_ext, evt_code}, 0);
    end
    chk("held_cnt", held_cnt, m_held.size());
    chk("press_cnt", press_cnt, m_press);
    chk("caps", caps, m_caps);
    chk("overflow", overflow, m_ovf);
    chk("cur_code", cur_code, m_cur() & 9'h0FF);
    chk("cur_ext", cur_ext, m_cur() >> 8);
    chk("ascii", ascii, m_ascii());
    nd_low = !bus.nextdata_n;
    if (nd_low) chk("nextdata_single_cycle", prev_nd_low, 0);
    prev_nd_low = nd_low;
    if (evt_valid) begin
      last_evt = {evt_make, evt_ext, evt_code};
      if (evt_ext) ext_evt_cnt++;
    end
    if (pop_flag) begin
      pend_byte = fifo.pop_front();
      pop_cnt++;
      apply_pending = !reset_n;
      pop_flag = 0;
    end
    bus.ps2_ready = (fifo.size() != 0);
    bus.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  always @(posedge clk) if (!bus.nextdata_n && !reset_n) pop_flag = 1;

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #3;
      if (fifo.size() == 0 && !apply_pending && !pop_flag) done = 1;
    end
    if (!done) chk("idle_timeout", 1, 0);
    @(negedge clk); #3;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1;
    fifo.delete();
    @(negedge clk); #3;
    chk("rst_held", held_cnt, 0);
    chk("rst_press", press_cnt, 0);
    chk("rst_cur", {cur_ext, cur_code}, 0);
    chk("rst_ascii", ascii, 0);
    chk("rst_flags", {evt_valid, caps, overflow}, 0);
    @(negedge clk); #2 reset_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, x0;
    bit found;
    reset_n = 1;
    bus.ps2_ready = 0;
    bus.ps2_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Single make then break
    do_reset();
    push(8'h1C); wait_idle(100);
    chk("t1_cur", cur_code, 8'h1C);
    chk("t1_ascii", ascii, 8'h61);
    chk("t1_evt", last_evt, {1'b1, 1'b0, 8'h1C});
    push(8'hF0); push(8'h1C); wait_idle(100);
    chk("t1_held", held_cnt, 0);
    chk("t1_ascii0", ascii, 8'h00);
    chk("t1_press", press_cnt, 1);
    chk("t1_brk_evt", last_evt, {1'b0, 1'b0, 8'h1C});

    // Shift with typematic repeats
    do_reset();
    push(8'h12); push(8'h1C); push(8'h1C); push(8'h1C); wait_idle(100);
    chk("t2_press", press_cnt, 2);
    chk("t2_cur", cur_code, 8'h1C);
    chk("t2_ascii", ascii, 8'h41);
    push(8'hF0); push(8'h12); wait_idle(100);
    chk("t2_cur_after", cur_code, 8'h1C);
    chk("t2_ascii_after", ascii, 8'h61);
    chk("t2_held", held_cnt, 1);

    // Extended key make/break
    do_reset();
    p0 = pop_cnt; x0 = ext_evt_cnt;
    push(8'hE0); push(8'h75); wait_idle(100);
    chk("t3_cur", {cur_ext, cur_code}, {1'b1, 8'h75});
    chk("t3_ascii", ascii, 8'h00);
    push(8'hE0); push(8'hF0); push(8'h75); wait_idle(100);
    chk("t3_held", held_cnt, 0);
    chk("t3_pops", pop_cnt - p0, 5);
    chk("t3_ext_evts", ext_evt_cnt - x0, 2);

    // Table overflow and mid-table removal
    do_reset();
    push(8'h1C); push(8'h32); push(8'h21); push(8'h23); push(8'h24); wait_idle(100);
    chk("t4_ovf", overflow, 1);
    chk("t4_held", held_cnt, 4);
    chk("t4_press", press_cnt, 4);
    push(8'hF0); push(8'h32); wait_idle(100);
    chk("t4_cur", cur_code, 8'h23);
    chk("t4_ovf0", overflow, 0);
    chk("t4_held3", held_cnt, 3);
    push(8'hF0); push(8'h23); wait_idle(100);
    chk("t4_cur2", cur_code, 8'h21);

    // Caps lock
    do_reset();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C); wait_idle(100);
    chk("t5_caps", caps, 1);
    chk("t5_ascii", ascii, 8'h41);

    // Press counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin push(8'h1C); push(8'hF0); push(8'h1C); end
    wait_idle(3000);
    chk("t5_press_ff", press_cnt, 8'hFF);
    push(8'h1C); wait_idle(100);
    chk("t5_press_wrap", press_cnt, 8'h00);

    // Reset while the FIFO pop strobe is active
    do_reset();
    push(8'h1C); wait_idle(100);
    push(8'h32);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (bus.nextdata_n == 1'b0) found = 1;
    end
    chk("t6_found_pop", found, 1);
    reset_n = 1;
    #1;
    chk("t6_nextdata_n", bus.nextdata_n, 1);
    chk("t6_outputs", {held_cnt, cur_code, ascii, press_cnt}, 0);
    @(negedge clk); #3;
    chk("t6_fifo_kept", fifo.size(), 1);
    reset_n = 0;
    wait_idle(100);
    chk("t6_cur", cur_code, 8'h32);
    chk("t6_held", held_cnt, 1);
    chk("t6_press", press_cnt, 1);

    // Randomized key traffic
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] k;
      k = pool[$urandom_range(0, 13)];
      r = $urandom_range(0, 99);
      if (r < 10) push(junk[$urandom_range(0, 4)]);
      if ($urandom_range(0, 3) == 0) push(8'hE0);
      if ($urandom_range(0, 19) == 0) push(8'hE0);
      if (r >= 45) push(8'hF0);
      push(k);
      if ($urandom_range(0, 3) == 0) wait_idle(200);
    end
    wait_idle(5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
